// File: rtl/triangle_scheduler_if.sv
// Control bundle between the frame scheduler and the three-stage
// triangle datapath (fetch, vertex, pixel).
interface triangle_scheduler_if #(
    parameter int MADDR_WIDTH = 32
);
    logic                   fetch_start;
    logic                   ver_start;
    logic                   pix_start;
    logic                   ld_ver;
    logic                   ld_pix;
    logic                   fetch_eoc;
    logic                   ver_eoc;
    logic                   pix_eoc;
    logic [MADDR_WIDTH-1:0] addr_vertex;
    logic [MADDR_WIDTH-1:0] addr_color;

    modport master (
        output fetch_start, ver_start, pix_start,
        output ld_ver, ld_pix,
        output addr_vertex, addr_color,
        input  fetch_eoc, ver_eoc, pix_eoc
    );

    modport slave (
        input  fetch_start, ver_start, pix_start,
        input  ld_ver, ld_pix,
        input  addr_vertex, addr_color,
        output fetch_eoc, ver_eoc, pix_eoc
    );
endinterface

// File: rtl/triangle_scheduler.sv
// Frame sequencer: walks triangle indices and keeps up to three
// triangles in flight across fetch, vertex and pixel stages.
module triangle_scheduler #(
    parameter int MADDR_WIDTH = 32,
    parameter int VERTEX_SIZE = 6,
    parameter int COLOR_SIZE  = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   frame_start,
    input  logic [31:0]            triangles_count,
    input  logic [MADDR_WIDTH-1:0] base_addr_vertex,
    input  logic [MADDR_WIDTH-1:0] base_addr_color,
    input  logic                   interrupt_ack,
    triangle_scheduler_if.master   dp,
    output logic                   busy,
    output logic                   frame_done,
    output logic                   irq,
    output logic                   overrun
);
    typedef enum logic [2:0] {
        IDLE, ISSUE, SETTLE, RUN, DONE
    } state_t;

    localparam logic [MADDR_WIDTH-1:0] V_STRIDE =
        MADDR_WIDTH'(3 * VERTEX_SIZE);
    localparam logic [MADDR_WIDTH-1:0] C_STRIDE =
        MADDR_WIDTH'(COLOR_SIZE);

    state_t                 state, state_nx;
    logic [31:0]            count, issued, retired;
    logic                   v_f, v_v, v_p;
    logic [MADDR_WIDTH-1:0] ptr_v, ptr_c;
    logic [MADDR_WIDTH-1:0] addr_v_q, addr_c_q;
    logic                   zero_hold;
    logic                   more_fetch, stages_done, last_retire;

    assign more_fetch  = issued < count;
    assign stages_done = (!v_f || dp.fetch_eoc) &&
                         (!v_v || dp.ver_eoc) &&
                         (!v_p || dp.pix_eoc);
    assign last_retire = (retired + 32'(v_p)) == count;

    assign dp.addr_vertex = addr_v_q;
    assign dp.addr_color  = addr_c_q;

    always_comb begin
        state_nx       = state;
        dp.fetch_start = 1'b0;
        dp.ver_start   = 1'b0;
        dp.pix_start   = 1'b0;
        dp.ld_ver      = 1'b0;
        dp.ld_pix      = 1'b0;
        frame_done     = 1'b0;
        busy           = (state != IDLE);
        unique case (state)
            IDLE: begin
                if (frame_start)
                    state_nx = (triangles_count == 32'd0) ? DONE : ISSUE;
            end
            ISSUE: begin
                dp.fetch_start = more_fetch;
                dp.ver_start   = v_f;
                dp.ld_ver      = v_f;
                dp.pix_start   = v_v;
                dp.ld_pix      = v_v;
                state_nx       = SETTLE;
            end
            SETTLE: state_nx = RUN;
            RUN: begin
                if (stages_done)
                    state_nx = last_retire ? DONE : ISSUE;
            end
            DONE: begin
                // empty frames linger one cycle so completion lands at cycle 2
                frame_done = !zero_hold;
                if (!zero_hold)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            count     <= '0;
            issued    <= '0;
            retired   <= '0;
            v_f       <= 1'b0;
            v_v       <= 1'b0;
            v_p       <= 1'b0;
            ptr_v     <= '0;
            ptr_c     <= '0;
            addr_v_q  <= '0;
            addr_c_q  <= '0;
            zero_hold <= 1'b0;
            irq       <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state <= state_nx;
            unique case (state)
                IDLE: begin
                    if (frame_start) begin
                        count     <= triangles_count;
                        issued    <= '0;
                        retired   <= '0;
                        v_f       <= 1'b0;
                        v_v       <= 1'b0;
                        v_p       <= 1'b0;
                        zero_hold <= (triangles_count == 32'd0);
                        if (triangles_count != 32'd0) begin
                            addr_v_q <= base_addr_vertex;
                            addr_c_q <= base_addr_color;
                            ptr_v    <= base_addr_vertex + V_STRIDE;
                            ptr_c    <= base_addr_color + C_STRIDE;
                        end
                    end
                end
                ISSUE: begin
                    v_p <= v_v;
                    v_v <= v_f;
                    v_f <= more_fetch;
                    if (more_fetch)
                        issued <= issued + 32'd1;
                end
                RUN: begin
                    if (stages_done) begin
                        if (v_p)
                            retired <= retired + 32'd1;
                        // next fetch address is staged one cycle ahead of its pulse
                        if (!last_retire && more_fetch) begin
                            addr_v_q <= ptr_v;
                            addr_c_q <= ptr_c;
                            ptr_v    <= ptr_v + V_STRIDE;
                            ptr_c    <= ptr_c + C_STRIDE;
                        end
                    end
                end
                DONE: zero_hold <= 1'b0;
                default: ;
            endcase
            if (state == DONE && !zero_hold)
                irq <= 1'b1;
            else if (interrupt_ack)
                irq <= 1'b0;
            if (frame_start && state != IDLE)
                overrun <= 1'b1;
            else if (interrupt_ack)
                overrun <= 1'b0;
        end
    end
endmodule

// File: tb/tb_triangle_scheduler.sv
// Scoreboard bench for triangle_scheduler: a slot-level timing model
// feeds an event queue that a negedge monitor drains.
module tb_triangle_scheduler;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        frame_start = 1'b0;
    logic        interrupt_ack = 1'b0;
    logic [31:0] triangles_count = '0;
    logic [31:0] base_addr_vertex = '0;
    logic [31:0] base_addr_color = '0;
    logic        busy, frame_done, irq, overrun;

    triangle_scheduler_if #(.MADDR_WIDTH(32)) sif();

    triangle_scheduler #(
        .MADDR_WIDTH(32),
        .VERTEX_SIZE(6),
        .COLOR_SIZE(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .frame_start(frame_start),
        .triangles_count(triangles_count),
        .base_addr_vertex(base_addr_vertex),
        .base_addr_color(base_addr_color),
        .interrupt_ack(interrupt_ack),
        .dp(sif),
        .busy(busy),
        .frame_done(frame_done),
        .irq(irq),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    typedef struct {
        int          cyc;
        bit          f, v, p, d;
        logic [31:0] av, ac;
    } ev_t;
    ev_t q[$];

    // datapath stand-in: each stage goes busy for a programmable time after its start
    int fd = 0, vd = 0, pd = 0;
    int fcnt = 0, vcnt = 0, pcnt = 0;
    always @(posedge clk) begin
        if (reset) begin
            fcnt <= 0;
            vcnt <= 0;
            pcnt <= 0;
        end else begin
            if (sif.fetch_start) fcnt <= fd;
            else if (fcnt > 0) fcnt <= fcnt - 1;
            if (sif.ver_start) vcnt <= vd;
            else if (vcnt > 0) vcnt <= vcnt - 1;
            if (sif.pix_start) pcnt <= pd;
            else if (pcnt > 0) pcnt <= pcnt - 1;
        end
    end
    assign sif.fetch_eoc = (fcnt == 0);
    assign sif.ver_eoc   = (vcnt == 0);
    assign sif.pix_eoc   = (pcnt == 0);

    ev_t me;
    always @(negedge clk) begin
        if (!reset && (sif.fetch_start || sif.ver_start ||
                       sif.pix_start || frame_done)) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_event cyc=%0d f=%b v=%b p=%b d=%b",
                         cyc, sif.fetch_start, sif.ver_start,
                         sif.pix_start, frame_done);
            end else begin
                me = q.pop_front();
                if (cyc != me.cyc || sif.fetch_start != me.f ||
                    sif.ver_start != me.v || sif.ld_ver != me.v ||
                    sif.pix_start != me.p || sif.ld_pix != me.p ||
                    frame_done != me.d ||
                    (me.f && (sif.addr_vertex != me.av ||
                              sif.addr_color != me.ac))) begin
                    bad++;
                    $display("FAIL event got cyc=%0d f%b v%b/%b p%b/%b d%b av=%h ac=%h exp cyc=%0d f%b v%b p%b d%b av=%h ac=%h",
                             cyc, sif.fetch_start, sif.ver_start, sif.ld_ver,
                             sif.pix_start, sif.ld_pix, frame_done,
                             sif.addr_vertex, sif.addr_color,
                             me.cyc, me.f, me.v, me.p, me.d, me.av, me.ac);
                end
            end
        end
    end

    // triangle k is fetched in slot k, vertexed in k+1, pixeled in k+2;
    // a slot lasts ISSUE+SETTLE plus the slowest busy stage started in it
    function automatic int model(int n, logic [31:0] bv, logic [31:0] bc,
                                 int t0, int cut);
        int  t;
        int  dm;
        ev_t e;
        e.av = '0;
        e.ac = '0;
        e.f  = 1'b0;
        e.v  = 1'b0;
        e.p  = 1'b0;
        e.d  = 1'b1;
        if (n == 0) begin
            e.cyc = t0 + 2;
            if (e.cyc < cut) q.push_back(e);
            return t0 + 2;
        end
        t = t0 + 1;
        for (int k = 0; k <= n + 1; k++) begin
            e.cyc = t;
            e.f   = (k < n);
            e.v   = (k >= 1 && k <= n);
            e.p   = (k >= 2);
            e.d   = 1'b0;
            e.av  = bv + 32'(k * 18);
            e.ac  = bc + 32'(k * 2);
            if (t < cut) q.push_back(e);
            dm = 0;
            if (e.f && fd > dm) dm = fd;
            if (e.v && vd > dm) dm = vd;
            if (e.p && pd > dm) dm = pd;
            t = t + ((dm + 1 > 2) ? dm + 1 : 2) + 1;
        end
        e.cyc = t;
        e.f   = 1'b0;
        e.v   = 1'b0;
        e.p   = 1'b0;
        e.d   = 1'b1;
        if (t < cut) q.push_back(e);
        return t;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic wait_until(int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_drained(string name);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL %s missing=%0d next_cyc=%0d", name, q.size(),
                     q[0].cyc);
            q.delete();
        end
    endtask

    task automatic launch(int n, logic [31:0] bv, logic [31:0] bc, int cut,
                          output int t0, output int dc);
        @(posedge clk);
        #1;
        triangles_count  = 32'(n);
        base_addr_vertex = bv;
        base_addr_color  = bc;
        frame_start      = 1'b1;
        t0 = cyc;
        dc = model(n, bv, bc, t0, cut);
        @(posedge clk);
        #1;
        frame_start = 1'b0;
    endtask

    task automatic finish_frame(string name, int dc);
        wait_until(dc + 1);
        chk_drained(name);
        chk({name, "_irq"}, 32'(irq), 32'd1);
        chk({name, "_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic ack_clear(string name);
        interrupt_ack = 1'b1;
        @(posedge clk);
        #1;
        interrupt_ack = 1'b0;
        chk({name, "_irq_clr"}, 32'(irq), 32'd0);
        chk({name, "_ovr_clr"}, 32'(overrun), 32'd0);
    endtask

    localparam int NOCUT = 32'h7fff_ffff;

    initial begin
        int t0, dc, n;
        logic [31:0] bv, bc;

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_done", 32'(frame_done), 32'd0);
        chk("rst_fetch", 32'(sif.fetch_start), 32'd0);
        chk("rst_addr_v", sif.addr_vertex, 32'd0);

        launch(3, 32'h1000, 32'h2000, NOCUT, t0, dc);
        finish_frame("n3", dc);
        ack_clear("n3");

        launch(0, 32'h5000, 32'h6000, NOCUT, t0, dc);
        chk("n0_busy", 32'(busy), 32'd1);
        finish_frame("n0", dc);
        ack_clear("n0");

        vd = 20;
        launch(2, 32'h3000, 32'h4000, NOCUT, t0, dc);
        finish_frame("stall", dc);
        vd = 0;
        ack_clear("stall");

        launch(3, 32'h1000, 32'h2000, NOCUT, t0, dc);
        wait_until(t0 + 5);
        triangles_count = 32'd7;
        frame_start = 1'b1;
        @(posedge clk);
        #1;
        frame_start = 1'b0;
        chk("ovr_set", 32'(overrun), 32'd1);
        finish_frame("ovr", dc);
        chk("ovr_sticky", 32'(overrun), 32'd1);
        ack_clear("ovr");

        launch(1, 32'hABC0, 32'hDEF0, NOCUT, t0, dc);
        wait_until(dc);
        interrupt_ack = 1'b1;
        @(posedge clk);
        #1;
        interrupt_ack = 1'b0;
        chk("ack_race_irq", 32'(irq), 32'd1);
        finish_frame("ack_race", dc);
        ack_clear("ack_race");

        launch(3, 32'h1000, 32'h2000, 0, t0, dc);
        t0 = t0;
        q.delete();
        void'(model(3, 32'h1000, 32'h2000, t0, t0 + 8));
        wait_until(t0 + 8);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_ver", 32'(sif.ver_start), 32'd0);
        chk("mid_rst_addr_v", sif.addr_vertex, 32'd0);
        chk("mid_rst_addr_c", sif.addr_color, 32'd0);
        chk("mid_rst_done", 32'(frame_done), 32'd0);
        chk_drained("mid_rst_events");
        launch(3, 32'h7700, 32'h8800, NOCUT, t0, dc);
        finish_frame("post_rst", dc);
        ack_clear("post_rst");

        for (int i = 0; i < 25; i++) begin
            n  = $urandom_range(0, 7);
            bv = $urandom;
            bc = $urandom;
            if (i % 5 == 0) begin
                bv = 32'hFFFF_FFF0;
                bc = 32'hFFFF_FFFC;
            end
            fd = $urandom_range(0, 4);
            vd = $urandom_range(0, 4);
            pd = $urandom_range(0, 4);
            launch(n, bv, bc, NOCUT, t0, dc);
            finish_frame("rand", dc);
            ack_clear("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1);
    end
endmodule

// File: doc/triangle_scheduler.md
Name: triangle_scheduler

Overview:
- Frame-level sequencer for the three-stage triangle datapath: data_fetch, vertex_computation and pixel_computation.
- After a frame_start from the register target, it walks triangle indices 0..count-1 and computes per-triangle vertex/color addresses.
- It issues start pulses and inter-stage load strobes so that up to three triangles are in flight, one per stage.
- It reports frame completion through a pulse and a sticky irq.

Parameters:
- MADDR_WIDTH, 32, master address width.
- VERTEX_SIZE, 6, bytes per vertex; triangle stride is 3*VERTEX_SIZE.
- COLOR_SIZE, 2, bytes per triangle color entry.

Ports:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high reset.
- frame_start  in  1  one-cycle frame request.
- triangles_count  in  32  triangles in frame; sampled on accepted frame_start.
- base_addr_vertex  in  MADDR_WIDTH  vertex buffer base; sampled with count.
- base_addr_color  in  MADDR_WIDTH  color buffer base; sampled with count.
- interrupt_ack  in  1  clears irq.
- fetch_eoc, ver_eoc, pix_eoc  in  1 each  stage idle/complete level; drops no earlier than the cycle after its start.
- fetch_start, ver_start, pix_start  out  1 each  stage start pulses.
- ld_ver  out  1  copy fetch results into vertex-stage input registers.
- ld_pix  out  1  copy vertex results and color into pixel-stage input registers.
- addr_vertex  out  MADDR_WIDTH  current fetch vertex address.
- addr_color  out  MADDR_WIDTH  current fetch color address.
- busy  out  1  frame in progress.
- frame_done  out  1  one-cycle completion pulse.
- irq  out  1  sticky frame interrupt.
- overrun  out  1  sticky: frame_start arrived while busy.

Behaviour:
- Reset values: all outputs 0; state IDLE; counters (issued, retired) 0; valid bits v_f, v_v, v_p 0. A reset mid-frame aborts immediately; no frame_done is produced.
- States are IDLE, ISSUE, SETTLE, RUN, DONE. All outputs are registered or decoded from the state register.
- IDLE:
  - frame_start latches count/bases.
  - count==0 -> DONE; otherwise -> ISSUE with a pending shift of v_f=1.
- ISSUE (exactly 1 cycle):
  - Apply the shift: v_p<=v_v, v_v<=v_f, v_f<=(issued<count).
  - Pulses: fetch_start if new v_f; ver_start with ld_ver if old v_f; pix_start with ld_pix if old v_v.
  - When a fetch is issued: addr_vertex = base_v + issued*3*VERTEX_SIZE, addr_color = base_c + issued*COLOR_SIZE, issued++. Both addresses are held stable until the next fetch issue.
  - -> SETTLE.
- SETTLE (1 cycle): masks stale eoc; -> RUN.
- RUN: wait until (!v_f|fetch_eoc) & (!v_v|ver_eoc) & (!v_p|pix_eoc).
  - On that condition: if v_p, retired++.
  - If retired (after increment) == count -> DONE; else -> ISSUE.
- DONE: frame_done=1 for 1 cycle; irq set; -> IDLE.
- Address arithmetic is modulo 2^MADDR_WIDTH; wrap is silent.
- busy=1 in every state except IDLE.
- frame_start outside IDLE is ignored and sets overrun. overrun clears on interrupt_ack.
- irq: set in DONE, cleared by interrupt_ack. If set and ack occur in the same cycle, set wins.
- Eoc inputs are ignored in IDLE, ISSUE, SETTLE and DONE.
- Latency with stages reporting eoc immediately, frame_start at cycle 0:
  - ISSUE cycles at 1, 4, 7, ...
  - frame_done at cycle 3N+7 for N>=1.
  - N=0: frame_done at cycle 2.

Test Plan:
- N=3, bases 0x1000/0x2000, eoc tied high:
  - fetch_start at cycles 1, 4, 7 with addr_vertex 0x1000, 0x1012, 0x1024 and addr_color 0x2000, 0x2002, 0x2004.
  - ver_start at 4, 7, 10; pix_start at 7, 10, 13.
  - frame_done at 16, irq=1 from 17.
- N=0 -> frame_done at cycle 2; no start pulses; irq set.
- N=2, ver_eoc held low 20 cycles after each ver_start -> no further start pulses until ver_eoc rises; retired ends at 2; exactly one frame_done.
- frame_start re-pulsed at cycle 5 of N=3 frame -> ignored, overrun=1, schedule unchanged; interrupt_ack clears overrun and irq.
- interrupt_ack asserted in the same cycle as DONE -> irq still 1 afterwards; a subsequent ack clears it.
- reset asserted at cycle 8 of N=3 frame -> next cycle all outputs 0, IDLE; a new frame_start runs cleanly from index 0.
